hram_dma: RTL and testbench
===========================

# hram_dma

Bus-initiator block that drives the SoC internal bus (`soc_rd`/`soc_wr`/`ffxx`/`a`/`d`) toward High RAM (FF80–FFFE). It is the master counterpart of the HRAM responder: it issues read and write strobes to copy a block of bytes inside HRAM, or fill a block with a constant. It sits beside the CPU bus interface and is used for boot-time HRAM clearing and for routine copies. Bus arbitration against the CPU is external.

## Interface
Parameters:
- `STROBE_CYC`, default 2: clocks each `soc_rd`/`soc_wr` strobe is held. Legal range is 1..4.

Ports:
- `clk7`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `mode`  in  1  operation select: 0 = copy, 1 = fill. Sampled with `start`.
- `src`  in  7  source offset; the byte address is FF80+src. Sampled with `start`.
- `dst`  in  7  destination offset; the byte address is FF80+dst. Sampled with `start`.
- `len`  in  7  byte count, 0..127. Sampled with `start`.
- `fill`  in  8  fill value. Sampled with `start`.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, on a rejected request.
- `soc_rd`  out  1  read strobe.
- `soc_wr`  out  1  write strobe.
- `ffxx`  out  1  FFxx page select; high whenever either strobe is high.
- `a`  out  8  low address byte; `a[7]`=1 during every strobe.
- `d`  inout  8  data bus; driven only while `soc_wr`=1, otherwise high-Z.

## Operation
- States: IDLE, CHECK, RD, WR, NEXT, FIN.
- Outputs are all registered. Reset values: `busy`=0, `done`=0, `err`=0, `soc_rd`=0, `soc_wr`=0, `ffxx`=0, `a`=8'h00, `d`=Z.
- **IDLE.** `start`=1 latches `mode`, `src`, `dst`, `len` and `fill`, then the block goes to CHECK.
- **CHECK** (single cycle, no strobes, `busy`=0). The checks use 8-bit sums:
  - `len`=0 → FIN with `err`=0.
  - `dst+len-1` > 7'h7E (the range would hit FFFF/IE or wrap) → FIN with `err`=1.
  - Copy mode and `src+len-1` > 7'h7E → FIN with `err`=1.
  - Otherwise `busy` is set, and the block goes to RD (copy) or WR (fill).
- **RD.** Drive `a`={1,src_ptr}, `ffxx`=1 and `soc_rd`=1 for `STROBE_CYC` cycles. Capture `d` into the data latch on the last clock edge of the strobe.
- **WR.** Drive `a`={1,dst_ptr}, `ffxx`=1 and `soc_wr`=1 for `STROBE_CYC` cycles. `d` carries the latch value (copy) or `fill` (fill).
- **NEXT** is folded into the last WR cycle, with no extra clock:
  - Increment both pointers and decrement the remaining count.
  - If the count is nonzero, go back to RD (copy) or WR (fill). Otherwise go to FIN.
- **FIN.** Strobes are 0, `busy`=0 and `done`=1 for one cycle, then IDLE.
- Copy runs strictly in ascending address order, one byte at a time. Overlapping ranges are legal. Example: with dst = src+1, the byte at src propagates across the whole destination.
- `start` while not in IDLE is ignored. Inputs may change freely after being sampled.
- `soc_rd` and `soc_wr` are never high in the same cycle. `d` is released in the same cycle `soc_wr` falls.
- `reset` mid-transfer: on the next edge every output returns to its reset value and `d` goes Z. No partial write strobe is extended past that edge. The transfer is abandoned.

## Timing
C = `STROBE_CYC`; N = `len`; cycle 0 is the edge at which `start` is sampled.
- **CHECK:** cycle 1.
- **Copy:**
  - Byte k (k = 0..N-1) has its RD strobe in cycles 2+2Ck .. 1+2Ck+C and its WR strobe in the C cycles that follow.
  - `done` is high in cycle 2+2CN; `busy` is high in cycles 2 .. 1+2CN.
- **Fill:**
  - Byte k has its WR strobe in cycles 2+Ck .. 1+Ck+C.
  - `done` is high in cycle 2+CN.
- **Rejected or `len`=0:** `done` (plus `err` if rejected) in cycle 2, with no strobes at all.
- A new `start` is accepted at the earliest in the cycle after `done`.
- Read data is taken from `d` while `soc_rd` is still asserted, at the final strobe edge. The responder must have data valid by then.

## Test plan
1. Fill, C=2, `dst`=0x00, `len`=3, `fill`=0xA5 → FF80, FF81 and FF82 read back 0xA5. Each `soc_wr` lasts 2 cycles; `done` in cycle 8; `err`=0.
2. Copy, C=2, preload FF90..FF93 = 11,22,33,44, `src`=0x10, `dst`=0x20, `len`=4 → FFA0..FFA3 = 11,22,33,44. `done` in cycle 18; `soc_rd`/`soc_wr` never overlap; `d` is Z whenever `soc_wr`=0.
3. Bounds:
   - `dst`=0x7C, `len`=4 → `done`=`err`=1 in cycle 2, no strobe, FFFF untouched.
   - `dst`=0x7B, `len`=4 → accepted, writes FFFB..FFFE.
   - `len`=0 → `done` in cycle 2 with `err`=0.
4. Overlap copy: FF80=0x07, `src`=0x00, `dst`=0x01, `len`=3 → FF81..FF83 = 0x07.
5. Assert `reset` in cycle 5 of a copy → on the next edge all outputs are at reset values and `d`=Z. A following fill runs correctly.
6. Pulse `start` (different args) mid-transfer → ignored; the original transfer completes unchanged. Repeat tests 1 and 2 with C=1 and C=4 to check the cycle formulas.

Source files
------------

// File: rtl/hram_dma_if.sv
// SoC internal bus strobes and address toward the FFxx page: initiator (master) and HRAM (slave) views.
// The bidirectional data byte d is a plain inout port of the initiator.
interface hram_dma_if;
  logic       soc_rd;
  logic       soc_wr;
  logic       ffxx;
  logic [7:0] a;

  modport master (output soc_rd, soc_wr, ffxx, a);
  modport slave  (input  soc_rd, soc_wr, ffxx, a);
endinterface

// File: rtl/hram_dma.sv
// HRAM block copy/fill initiator. It issues STROBE_CYC-long read and write strobes on the SoC bus.
// All outputs are registered from the current state, so they lag the FSM by one clock.
module hram_dma #(
  parameter int STROBE_CYC = 2
) (
  input  logic       clk7,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [6:0] src,
  input  logic [6:0] dst,
  input  logic [6:0] len,
  input  logic [7:0] fill,
  output logic       busy,
  output logic       done,
  output logic       err,
  hram_dma_if.master bus,
  inout  wire  [7:0] d
);

  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, FIN} state_t;

  state_t     state_q, state_d;
  logic [1:0] ph_q;
  logic       last;
  logic       mode_q;
  logic [6:0] src_ptr, dst_ptr, remain;
  logic [7:0] fill_q, data_q;
  logic [7:0] src_end, dst_end;
  logic       reject, reject_q;
  logic       soc_rd_q, soc_wr_q, ffxx_q;
  logic [7:0] a_q;

  assign last    = (ph_q == 2'(STROBE_CYC - 1));
  assign src_end = {1'b0, src_ptr} + {1'b0, remain} - 8'd1;
  assign dst_end = {1'b0, dst_ptr} + {1'b0, remain} - 8'd1;
  assign reject  = (dst_end > 8'h7E) || (!mode_q && (src_end > 8'h7E));

  // NOTE: every variable in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = CHECK;
      CHECK: begin
        if (remain == 7'd0 || reject) state_d = FIN;
        else                          state_d = mode_q ? WR : RD;
      end
      RD:    if (last) state_d = WR;
      // The NEXT step lives in the last WR clock: no extra cycle between bytes.
      WR: begin
        if (last) begin
          if (remain == 7'd1) state_d = FIN;
          else                state_d = mode_q ? WR : RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk7) begin
    if (reset) begin
      state_q <= IDLE;
      ph_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ph_q    <= ((state_q == RD || state_q == WR) && !last) ? ph_q + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk7) begin
    if (reset) begin
      mode_q   <= 1'b0;
      src_ptr  <= 7'd0;
      dst_ptr  <= 7'd0;
      remain   <= 7'd0;
      fill_q   <= 8'h00;
      reject_q <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      if (state_q == IDLE && start) begin
        mode_q  <= mode;
        src_ptr <= src;
        dst_ptr <= dst;
        remain  <= len;
        fill_q  <= fill;
      end
      if (state_q == CHECK) reject_q <= (remain != 7'd0) && reject;
      if (state_q == WR && last) begin
        src_ptr <= src_ptr + 7'd1;
        dst_ptr <= dst_ptr + 7'd1;
        remain  <= remain - 7'd1;
      end
      // Read strobe is still high but the FSM has left RD: this is its final edge.
      if (soc_rd_q && state_q != RD) data_q <= d;
    end
  end

  always_ff @(posedge clk7) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      soc_rd_q <= 1'b0;
      soc_wr_q <= 1'b0;
      ffxx_q   <= 1'b0;
      a_q      <= 8'h00;
    end else begin
      busy     <= (state_q == RD) || (state_q == WR);
      done     <= (state_q == FIN);
      err      <= (state_q == FIN) && reject_q;
      soc_rd_q <= (state_q == RD);
      soc_wr_q <= (state_q == WR);
      ffxx_q   <= (state_q == RD) || (state_q == WR);
      a_q      <= (state_q == RD) ? {1'b1, src_ptr} :
                  (state_q == WR) ? {1'b1, dst_ptr} : 8'h00;
    end
  end

  assign bus.soc_rd = soc_rd_q;
  assign bus.soc_wr = soc_wr_q;
  assign bus.ffxx   = ffxx_q;
  assign bus.a      = a_q;

  // The data bus follows the registered write strobe, so it is released in the cycle soc_wr falls.
  assign d = soc_wr_q ? (mode_q ? fill_q : data_q) : 8'hzz;

endmodule

// File: tb/tb_hram_dma.sv
// Directed bench for hram_dma: three instances (STROBE_CYC 1, 2, 4), each with its own HRAM responder model.
module tb_hram_dma;

  logic clk7 = 1'b0;
  always #5 clk7 = ~clk7;

  logic             reset;
  logic [2:0]       start_v;
  logic             mode;
  logic [6:0]       src, dst, len;
  logic [7:0]       fill;
  logic [2:0]       busy_v, done_v, err_v, rd_v, wr_v, ffxx_v;
  logic [2:0][7:0]  a_v, d_v;

  logic [7:0] mem [3][128];
  logic       clr_mem, poke_en;
  int         poke_sel;
  logic [6:0] poke_addr;
  logic [7:0] poke_data;

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int C = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    hram_dma_if bus ();
    wire [7:0] d;
    assign d = (bus.soc_rd && bus.ffxx && bus.a[7]) ? mem[g][bus.a[6:0]] : 8'hzz;

    hram_dma #(.STROBE_CYC(C)) dut (
      .clk7  (clk7),
      .reset (reset),
      .start (start_v[g]),
      .mode  (mode),
      .src   (src),
      .dst   (dst),
      .len   (len),
      .fill  (fill),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .err   (err_v[g]),
      .bus   (bus),
      .d     (d)
    );

    assign rd_v[g]   = bus.soc_rd;
    assign wr_v[g]   = bus.soc_wr;
    assign ffxx_v[g] = bus.ffxx;
    assign a_v[g]    = bus.a;
    assign d_v[g]    = d;
  end

  // HRAM responder: latches d on every write-strobe edge, FF80..FFFF indexed by a[6:0].
  always @(posedge clk7) begin
    if (clr_mem) begin
      for (int g = 0; g < 3; g++)
        for (int i = 0; i < 128; i++) mem[g][i] <= 8'h00;
    end else begin
      if (poke_en) mem[poke_sel][poke_addr] <= poke_data;
      for (int g = 0; g < 3; g++)
        if (wr_v[g] && ffxx_v[g] && a_v[g][7]) mem[g][a_v[g][6:0]] <= d_v[g];
    end
  end

  task automatic clear_mem;
    @(negedge clk7); clr_mem = 1'b1;
    @(negedge clk7); clr_mem = 1'b0;
  endtask

  task automatic poke(input int sel, input logic [6:0] addr, input logic [7:0] data);
    @(negedge clk7);
    poke_en = 1'b1; poke_sel = sel; poke_addr = addr; poke_data = data;
    @(negedge clk7);
    poke_en = 1'b0;
  endtask

  // Drives one request and compares every cycle against the timing formulas (cycle 0 = sampling edge).
  // rst_cyc >= 0 asserts reset during that cycle; rs_cyc >= 0 pulses a second start then.
  task automatic run_xfer(input int sel, input logic m, input logic [6:0] s, input logic [6:0] dd,
                          input logic [6:0] n, input logic [7:0] f, input logic accept,
                          input int exp_done, input logic exp_err, input int rst_cyc, input int rs_cyc,
                          output int done_at, output int bad_cyc, output int first_bad);
    int c, cyc, limit, span, rel, bi;
    logic in_win, e_rd, e_wr, e_done, ok;
    logic [7:0] e_a;
    c    = (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
    span = m ? c * int'(n) : 2 * c * int'(n);
    done_at = -1; bad_cyc = 0; first_bad = -1;
    @(negedge clk7);
    mode = m; src = s; dst = dd; len = n; fill = f; start_v[sel] = 1'b1;
    @(negedge clk7);
    start_v[sel] = 1'b0;
    mode = ~m; src = ~s; dst = ~dd; len = ~n; fill = ~f;
    cyc   = 0;
    limit = (exp_done >= 0) ? exp_done + 2 : rst_cyc + 3;
    while (cyc <= limit) begin
      in_win = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_a = 8'h00;
      if (accept && cyc >= 2 && cyc < 2 + span && (rst_cyc < 0 || cyc <= rst_cyc)) begin
        in_win = 1'b1;
        rel    = cyc - 2;
        if (m) begin
          e_wr = 1'b1;
          e_a  = {1'b1, 7'(int'(dd) + rel / c)};
        end else begin
          bi = rel / (2 * c);
          if (rel % (2 * c) < c) begin e_rd = 1'b1; e_a = {1'b1, 7'(int'(s) + bi)}; end
          else                   begin e_wr = 1'b1; e_a = {1'b1, 7'(int'(dd) + bi)}; end
        end
      end
      e_done = (cyc == exp_done);
      ok = (busy_v[sel] === in_win) && (rd_v[sel] === e_rd) && (wr_v[sel] === e_wr) &&
           (ffxx_v[sel] === (e_rd | e_wr)) && (done_v[sel] === e_done) &&
           (err_v[sel] === (e_done & exp_err));
      if (in_win && a_v[sel] !== e_a) ok = 1'b0;
      if (e_wr && m && d_v[sel] !== f) ok = 1'b0;
      if (!e_rd && !e_wr && !($isunknown(d_v[sel]) || d_v[sel] == 8'h00)) ok = 1'b0;
      if (!ok) begin
        bad_cyc++;
        if (first_bad < 0) first_bad = cyc;
      end
      if (done_v[sel] === 1'b1 && done_at < 0) done_at = cyc;
      if (rst_cyc >= 0 && cyc == rst_cyc)     reset = 1'b1;
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) reset = 1'b0;
      if (rs_cyc >= 0 && cyc == rs_cyc) begin
        start_v[sel] = 1'b1; mode = 1'b1; dst = 7'h00; len = 7'd1; fill = 8'hEE;
      end
      if (rs_cyc >= 0 && cyc == rs_cyc + 1) start_v[sel] = 1'b0;
      @(negedge clk7);
      cyc++;
    end
  endtask

  task automatic test_reset;
    for (int pass = 0; pass < 2; pass++) begin
      reset   = (pass == 0);
      clr_mem = (pass == 0);
      repeat (3) @(negedge clk7);
      for (int g = 0; g < 3; g++) begin
        n_cmp++;
        if ({busy_v[g], done_v[g], err_v[g], rd_v[g], wr_v[g], ffxx_v[g]} !== 6'b0 ||
            a_v[g] !== 8'h00 || !($isunknown(d_v[g]) || d_v[g] == 8'h00)) begin
          n_bad++;
          $display("FAIL reset_state inst%0d pass%0d: flags=%b a=%h d=%h, want flags=000000 a=00 d=z",
                   g, pass, {busy_v[g], done_v[g], err_v[g], rd_v[g], wr_v[g], ffxx_v[g]}, a_v[g], d_v[g]);
        end
      end
    end
  endtask

  task automatic test_fill(input int sel, input int exp_done);
    int done_at, bad_cyc, first_bad;
    clear_mem();
    run_xfer(sel, 1'b1, 7'h00, 7'h00, 7'd3, 8'hA5, 1'b1, exp_done, 1'b0, -1, -1, done_at, bad_cyc, first_bad);
    n_cmp++;
    if (bad_cyc !== 0) begin
      n_bad++; $display("FAIL fill_waveform inst%0d: %0d bad cycles (first %0d), want 0", sel, bad_cyc, first_bad);
    end
    n_cmp++;
    if (done_at !== exp_done) begin
      n_bad++; $display("FAIL fill_done_cycle inst%0d: got %0d, want %0d", sel, done_at, exp_done);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[sel][i] !== ((i < 3) ? 8'hA5 : 8'h00)) begin
        n_bad++; $display("FAIL fill_mem inst%0d FF%h: got %h, want %h", sel, 8'h80 + 8'(i), mem[sel][i],
                          (i < 3) ? 8'hA5 : 8'h00);
      end
    end
  endtask

  task automatic test_copy(input int sel, input int exp_done);
    int done_at, bad_cyc, first_bad;
    logic [7:0] pat [4];
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_mem();
    for (int i = 0; i < 4; i++) poke(sel, 7'(16 + i), pat[i]);
    run_xfer(sel, 1'b0, 7'h10, 7'h20, 7'd4, 8'h00, 1'b1, exp_done, 1'b0, -1, -1, done_at, bad_cyc, first_bad);
    n_cmp++;
    if (bad_cyc !== 0) begin
      n_bad++; $display("FAIL copy_waveform inst%0d: %0d bad cycles (first %0d), want 0", sel, bad_cyc, first_bad);
    end
    n_cmp++;
    if (done_at !== exp_done) begin
      n_bad++; $display("FAIL copy_done_cycle inst%0d: got %0d, want %0d", sel, done_at, exp_done);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[sel][32 + i] !== pat[i]) begin
        n_bad++; $display("FAIL copy_mem inst%0d FF%h: got %h, want %h", sel, 8'hA0 + 8'(i), mem[sel][32 + i], pat[i]);
      end
    end
  endtask

  task automatic test_bounds;
    int done_at, bad_cyc, first_bad;
    clear_mem();
    poke(1, 7'h7F, 8'h5A);
    run_xfer(1, 1'b1, 7'h00, 7'h7C, 7'd4, 8'h11, 1'b0, 2, 1'b1, -1, -1, done_at, bad_cyc, first_bad);
    n_cmp++;
    if (bad_cyc !== 0 || done_at !== 2) begin
      n_bad++; $display("FAIL bound_dst_reject: bad=%0d done=%0d, want bad=0 done=2", bad_cyc, done_at);
    end
    run_xfer(1, 1'b0, 7'h7D, 7'h00, 7'd3, 8'h00, 1'b0, 2, 1'b1, -1, -1, done_at, bad_cyc, first_bad);
    n_cmp++;
    if (bad_cyc !== 0 || done_at !== 2) begin
      n_bad++; $display("FAIL bound_src_reject: bad=%0d done=%0d, want bad=0 done=2", bad_cyc, done_at);
    end
    run_xfer(1, 1'b1, 7'h00, 7'h7B, 7'd4, 8'hC3, 1'b1, 10, 1'b0, -1, -1, done_at, bad_cyc, first_bad);
    n_cmp++;
    if (bad_cyc !== 0 || done_at !== 10) begin
      n_bad++; $display("FAIL bound_dst_edge: bad=%0d (first %0d) done=%0d, want bad=0 done=10", bad_cyc, first_bad, done_at);
    end
    for (int i = 123; i < 128; i++) begin
      n_cmp++;
      if (mem[1][i] !== ((i < 127) ? 8'hC3 : 8'h5A)) begin
        n_bad++; $display("FAIL bound_mem FF%h: got %h, want %h", 8'h80 + 8'(i), mem[1][i], (i < 127) ? 8'hC3 : 8'h5A);
      end
    end
    run_xfer(1, 1'b1, 7'h00, 7'h10, 7'd0, 8'h77, 1'b0, 2, 1'b0, -1, -1, done_at, bad_cyc, first_bad);
    n_cmp++;
    if (bad_cyc !== 0 || done_at !== 2) begin
      n_bad++; $display("FAIL bound_len_zero: bad=%0d done=%0d, want bad=0 done=2", bad_cyc, done_at);
    end
    n_cmp++;
    if (mem[1][16] !== 8'h00) begin
      n_bad++; $display("FAIL bound_len_zero_mem FF90: got %h, want 00", mem[1][16]);
    end
  endtask

  task automatic test_overlap;
    int done_at, bad_cyc, first_bad;
    clear_mem();
    poke(1, 7'h00, 8'h07);
    for (int i = 1; i < 4; i++) poke(1, 7'(i), 8'h99);
    run_xfer(1, 1'b0, 7'h00, 7'h01, 7'd3, 8'h00, 1'b1, 14, 1'b0, -1, -1, done_at, bad_cyc, first_bad);
    n_cmp++;
    if (bad_cyc !== 0 || done_at !== 14) begin
      n_bad++; $display("FAIL overlap_run: bad=%0d (first %0d) done=%0d, want bad=0 done=14", bad_cyc, first_bad, done_at);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (mem[1][i] !== ((i < 4) ? 8'h07 : 8'h00)) begin
        n_bad++; $display("FAIL overlap_mem FF%h: got %h, want %h", 8'h80 + 8'(i), mem[1][i], (i < 4) ? 8'h07 : 8'h00);
      end
    end
  endtask

  task automatic test_reset_abort;
    int done_at, bad_cyc, first_bad;
    clear_mem();
    for (int i = 0; i < 4; i++) poke(1, 7'(16 + i), 8'(8'h11 * (i + 1)));
    run_xfer(1, 1'b0, 7'h10, 7'h30, 7'd4, 8'h00, 1'b1, -1, 1'b0, 5, -1, done_at, bad_cyc, first_bad);
    n_cmp++;
    if (bad_cyc !== 0 || done_at !== -1) begin
      n_bad++; $display("FAIL abort_run: bad=%0d (first %0d) done=%0d, want bad=0 done=-1", bad_cyc, first_bad, done_at);
    end
    n_cmp++;
    if (mem[1][48] !== 8'h11 || mem[1][49] !== 8'h00) begin
      n_bad++; $display("FAIL abort_mem FFB0/FFB1: got %h/%h, want 11/00", mem[1][48], mem[1][49]);
    end
    run_xfer(1, 1'b1, 7'h00, 7'h40, 7'd2, 8'h3C, 1'b1, 6, 1'b0, -1, -1, done_at, bad_cyc, first_bad);
    n_cmp++;
    if (bad_cyc !== 0 || done_at !== 6) begin
      n_bad++; $display("FAIL abort_then_fill: bad=%0d (first %0d) done=%0d, want bad=0 done=6", bad_cyc, first_bad, done_at);
    end
    n_cmp++;
    if (mem[1][64] !== 8'h3C || mem[1][65] !== 8'h3C || mem[1][66] !== 8'h00) begin
      n_bad++; $display("FAIL abort_fill_mem FFC0..FFC2: got %h %h %h, want 3c 3c 00", mem[1][64], mem[1][65], mem[1][66]);
    end
  endtask

  task automatic test_ignore_start;
    int done_at, bad_cyc, first_bad;
    clear_mem();
    poke(1, 7'h00, 8'h77);
    run_xfer(1, 1'b1, 7'h00, 7'h50, 7'd3, 8'h66, 1'b1, 8, 1'b0, -1, 4, done_at, bad_cyc, first_bad);
    n_cmp++;
    if (bad_cyc !== 0 || done_at !== 8) begin
      n_bad++; $display("FAIL ignore_start_run: bad=%0d (first %0d) done=%0d, want bad=0 done=8", bad_cyc, first_bad, done_at);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mem[1][80 + i] !== 8'h66) begin
        n_bad++; $display("FAIL ignore_start_mem FF%h: got %h, want 66", 8'hD0 + 8'(i), mem[1][80 + i]);
      end
    end
    n_cmp++;
    if (mem[1][0] !== 8'h77) begin
      n_bad++; $display("FAIL ignore_start_untouched FF80: got %h, want 77", mem[1][0]);
    end
  endtask

  initial begin
    reset = 1'b1; start_v = 3'b000; mode = 1'b0; src = 7'h00; dst = 7'h00; len = 7'h00; fill = 8'h00;
    clr_mem = 1'b1; poke_en = 1'b0; poke_sel = 0; poke_addr = 7'h00; poke_data = 8'h00;
    test_reset();
    test_fill(1, 8);
    test_copy(1, 18);
    test_bounds();
    test_overlap();
    test_reset_abort();
    test_ignore_start();
    test_fill(0, 5);
    test_copy(0, 10);
    test_fill(2, 14);
    test_copy(2, 34);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
